// File: rtl/rtc_read_cycle_if.sv
// Bus and handshake bundle between the RTC control FSM, the read-cycle
// sequencer and the A/D bus tri-state pads.
interface rtc_read_cycle_if;
  logic       start;
  logic [7:0] addr_in;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       A_D;
  logic       CS;
  logic       WR;
  logic       RD;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       done;

  // Sequencer side
  modport master (
    input  start, addr_in, bus_in,
    output bus_out, bus_oe, A_D, CS, WR, RD, data_out, data_valid, busy, done
  );

  // Controller / pad side
  modport slave (
    output start, addr_in, bus_in,
    input  bus_out, bus_oe, A_D, CS, WR, RD, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/rtc_read_cycle.sv
// V3023 RTC read-cycle sequencer: address phase (A_D low, CS/WR strobe) followed
// by data phase (A_D high, CS/RD strobe, bus released), capturing the RTC byte.
// Every phase is self-timed by one shared 8-bit down-counter loaded with T_x-1.
module rtc_read_cycle #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_WR    = 10,
  parameter int unsigned T_HOLD  = 3,
  parameter int unsigned T_GAP   = 15,
  parameter int unsigned T_RD    = 10,
  parameter int unsigned T_REC   = 70
) (
  input logic              Clock_in,
  input logic              Reset,
  rtc_read_cycle_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    GAP,
    DATA_STROBE,
    RECOVER,
    DONE
  } state_t;

  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_WR    = 8'(T_WR - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);
  localparam logic [7:0] LD_RD    = 8'(T_RD - 1);
  localparam logic [7:0] LD_REC   = 8'(T_REC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       cnt_zero;
  logic       accept;
  logic       capture;

  assign cnt_zero = (cnt_q == 8'd0);
  assign accept   = (state_q == IDLE) && bus.start;
  // Capture on the edge that ends the final RD-low cycle.
  assign capture  = (state_q == DATA_STROBE) && cnt_zero;

  // Next-state and phase-counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ADDR_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      ADDR_SETUP: begin
        if (cnt_zero) begin
          state_d = ADDR_STROBE;
          cnt_d   = LD_WR;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ADDR_STROBE: begin
        if (cnt_zero) begin
          state_d = ADDR_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ADDR_HOLD: begin
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d = DATA_STROBE;
          cnt_d   = LD_RD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DATA_STROBE: begin
        if (cnt_zero) begin
          state_d = RECOVER;
          cnt_d   = LD_REC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt_zero) begin
          state_d = DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        // Start is deliberately ignored here; a new request is taken from IDLE only.
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, counter and captured-data registers
  always_ff @(posedge Clock_in) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= 1'b1;
      end
      if (capture) begin
        data_q <= bus.bus_in;
      end
    end
  end

  // Address latch; only observable while bus_oe is high, so it needs no reset
  always_ff @(posedge Clock_in) begin
    if (accept) begin
      addr_q <= bus.addr_in;
    end
  end

  // Moore decode of strobes and pad enable from the current state
  always_comb begin
    bus.A_D    = 1'b1;
    bus.CS     = 1'b1;
    bus.WR     = 1'b1;
    bus.RD     = 1'b1;
    bus.bus_oe = 1'b0;
    unique case (state_q)
      ADDR_SETUP: begin
        bus.A_D    = 1'b0;
        bus.bus_oe = 1'b1;
      end
      ADDR_STROBE: begin
        bus.A_D    = 1'b0;
        bus.CS     = 1'b0;
        bus.WR     = 1'b0;
        bus.bus_oe = 1'b1;
      end
      ADDR_HOLD: begin
        bus.A_D    = 1'b0;
        bus.bus_oe = 1'b1;
      end
      DATA_STROBE: begin
        bus.CS = 1'b0;
        bus.RD = 1'b0;
      end
      default: begin
        bus.A_D = 1'b1;
      end
    endcase
    bus.bus_out    = bus.bus_oe ? addr_q : 8'd0;
    bus.data_out   = data_q;
    bus.data_valid = valid_q;
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_rtc_read_cycle.sv
// Bench for rtc_read_cycle: a default-timed instance and an all-ones-timed
// instance, each followed cycle by cycle by a phase-offset model.
module tb_rtc_read_cycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtc_read_cycle_if bi0 ();
  rtc_read_cycle_if bi1 ();

  rtc_read_cycle dut0 (
    .Clock_in(clk),
    .Reset   (rst),
    .bus     (bi0)
  );

  rtc_read_cycle #(
    .T_SETUP(1), .T_WR(1), .T_HOLD(1), .T_GAP(1), .T_RD(1), .T_REC(1)
  ) dut1 (
    .Clock_in(clk),
    .Reset   (rst),
    .bus     (bi1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Phase lengths per instance: SETUP, WR, HOLD, GAP, RD, REC
  int tp [2][6];

  // Model: is a cycle in flight, which cycle of it (0 = first setup cycle), etc.
  bit         m_act [2];
  int         m_c   [2];
  logic [7:0] m_a   [2];
  logic [7:0] m_d   [2];
  logic       m_v   [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle offset at which phase k begins (k=6 gives the DONE cycle offset).
  function automatic int bnd(input int i, input int k);
    int s = 0;
    for (int j = 0; j < k; j++) s += tp[i][j];
    return s;
  endfunction

  task automatic model_step(input int i, input logic r, input logic st,
                            input logic [7:0] ad, input logic [7:0] bin);
    if (r) begin
      m_act[i] = 0; m_c[i] = 0; m_d[i] = 8'd0; m_v[i] = 1'b0;
    end else if (m_act[i]) begin
      if (m_c[i] == bnd(i, 5) - 1) begin
        m_d[i] = bin; m_v[i] = 1'b1;
      end
      if (m_c[i] == bnd(i, 6)) m_act[i] = 0;
      else m_c[i]++;
    end else if (st) begin
      m_act[i] = 1; m_c[i] = 0; m_a[i] = ad; m_v[i] = 1'b0;
    end
  endtask

  task automatic cmp_inst(input int i, input logic ad, input logic cs, input logic wr,
                          input logic rd, input logic oe, input logic [7:0] bo,
                          input logic by, input logic dn, input logic [7:0] dout,
                          input logic dv);
    logic e_ad, e_cs, e_wr, e_rd, e_oe, e_dn;
    int c;
    e_ad = 1; e_cs = 1; e_wr = 1; e_rd = 1; e_oe = 0; e_dn = 0;
    c = m_c[i];
    if (m_act[i]) begin
      if (c < bnd(i, 1)) begin
        e_ad = 0; e_oe = 1;
      end else if (c < bnd(i, 2)) begin
        e_ad = 0; e_cs = 0; e_wr = 0; e_oe = 1;
      end else if (c < bnd(i, 3)) begin
        e_ad = 0; e_oe = 1;
      end else if (c < bnd(i, 4)) begin
        e_ad = 1;
      end else if (c < bnd(i, 5)) begin
        e_cs = 0; e_rd = 0;
      end else if (c == bnd(i, 6)) begin
        e_dn = 1;
      end
    end
    chk($sformatf("A_D[%0d]", i), int'(ad), int'(e_ad));
    chk($sformatf("CS[%0d]", i), int'(cs), int'(e_cs));
    chk($sformatf("WR[%0d]", i), int'(wr), int'(e_wr));
    chk($sformatf("RD[%0d]", i), int'(rd), int'(e_rd));
    chk($sformatf("bus_oe[%0d]", i), int'(oe), int'(e_oe));
    chk($sformatf("bus_out[%0d]", i), int'(bo), e_oe ? int'(m_a[i]) : 0);
    chk($sformatf("busy[%0d]", i), int'(by), int'(m_act[i]));
    chk($sformatf("done[%0d]", i), int'(dn), int'(e_dn));
    chk($sformatf("data_out[%0d]", i), int'(dout), int'(m_d[i]));
    chk($sformatf("data_valid[%0d]", i), int'(dv), int'(m_v[i]));
    chk($sformatf("inv_oe_rd[%0d]", i), int'(oe && !rd), 0);
    chk($sformatf("inv_wr_rd[%0d]", i), int'(!wr && !rd), 0);
    chk($sformatf("inv_cs[%0d]", i), int'(!cs), int'(!wr || !rd));
  endtask

  // Model advances on every rising edge with the inputs the DUT sees
  always @(posedge clk) begin
    cyc++;
    model_step(0, rst, bi0.start, bi0.addr_in, bi0.bus_in);
    model_step(1, rst, bi1.start, bi1.addr_in, bi1.bus_in);
  end

  // Compare both DUTs against the model mid-cycle
  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp_inst(0, bi0.A_D, bi0.CS, bi0.WR, bi0.RD, bi0.bus_oe, bi0.bus_out,
               bi0.busy, bi0.done, bi0.data_out, bi0.data_valid);
      cmp_inst(1, bi1.A_D, bi1.CS, bi1.WR, bi1.RD, bi1.bus_oe, bi1.bus_out,
               bi1.busy, bi1.done, bi1.data_out, bi1.data_valid);
    end
  end

  task automatic set_start(input int i, input logic v);
    if (i == 0) bi0.start = v; else bi1.start = v;
  endtask
  task automatic set_addr(input int i, input logic [7:0] v);
    if (i == 0) bi0.addr_in = v; else bi1.addr_in = v;
  endtask
  task automatic set_bus(input int i, input logic [7:0] v);
    if (i == 0) bi0.bus_in = v; else bi1.bus_in = v;
  endtask

  // Called at the negedge of cycle 0 of an accepted read; returns at the
  // negedge of the done cycle. lat counts from the start edge to the edge
  // that ends the done pulse.
  task automatic wait_done(input int i, input int chg_c, input logic [7:0] chg_val,
                           input logic [7:0] addr, output int lat, output int wr,
                           output int rd, output int oe);
    int c = 0;
    logic s_wr, s_rd, s_oe, s_dn;
    logic [7:0] s_bo;
    lat = -1; wr = 0; rd = 0; oe = 0;
    while (c < 400) begin
      if (i == 0) begin
        s_wr = bi0.WR; s_rd = bi0.RD; s_oe = bi0.bus_oe; s_dn = bi0.done; s_bo = bi0.bus_out;
      end else begin
        s_wr = bi1.WR; s_rd = bi1.RD; s_oe = bi1.bus_oe; s_dn = bi1.done; s_bo = bi1.bus_out;
      end
      if (c == chg_c) set_bus(i, chg_val);
      if (!s_wr) wr++;
      if (!s_rd) rd++;
      if (s_oe && s_bo == addr) oe++;
      if (s_dn) begin
        lat = c + 1;
        break;
      end
      @(negedge clk);
      c++;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_cycle(input int i, input logic [7:0] addr, input logic [7:0] b0,
                           input int chg_c, input logic [7:0] chg_val, input bit hold,
                           output int lat, output int wr, output int rd, output int oe);
    set_start(i, 1'b1); set_addr(i, addr); set_bus(i, b0);
    @(negedge clk);
    if (!hold) set_start(i, 1'b0);
    wait_done(i, chg_c, chg_val, addr, lat, wr, rd, oe);
  endtask

  initial begin
    int lat, wr, rd, oe, dn;
    for (int k = 0; k < 6; k++) tp[1][k] = 1;
    tp[0][0] = 2; tp[0][1] = 10; tp[0][2] = 3; tp[0][3] = 15; tp[0][4] = 10; tp[0][5] = 70;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_c[k] = 0; m_a[k] = 8'd0; m_d[k] = 8'd0; m_v[k] = 1'b0;
    end
    bi0.start = 0; bi0.addr_in = 8'd0; bi0.bus_in = 8'd0;
    bi1.start = 0; bi1.addr_in = 8'd0; bi1.bus_in = 8'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_A_D", int'(bi0.A_D), 1);
    chk("rst_CS", int'(bi0.CS), 1);
    chk("rst_RD", int'(bi0.RD), 1);
    chk("rst_bus_oe", int'(bi0.bus_oe), 0);
    chk("rst_bus_out", int'(bi0.bus_out), 0);
    chk("rst_data_out", int'(bi0.data_out), 0);
    chk("rst_data_valid", int'(bi0.data_valid), 0);
    chk("rst_busy", int'(bi1.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read of address 0x21 returning 0x5A
    run_cycle(0, 8'h21, 8'h5A, -1, 8'h00, 0, lat, wr, rd, oe);
    chk("t1_latency", lat, 111);
    chk("t1_wr_low", wr, 10);
    chk("t1_rd_low", rd, 10);
    chk("t1_addr_drive", oe, 15);
    @(negedge clk);
    chk("t1_data_out", int'(bi0.data_out), 8'h5A);
    chk("t1_data_valid", int'(bi0.data_valid), 1);
    chk("t1_idle", int'(bi0.busy), 0);

    // Start held high: one cycle, next one accepted only from IDLE
    run_cycle(0, 8'h33, 8'hC3, -1, 8'h00, 1, lat, wr, rd, oe);
    chk("t2_latency_a", lat, 111);
    @(negedge clk);
    chk("t2_idle_gap", int'(bi0.busy), 0);
    chk("t2_data_out", int'(bi0.data_out), 8'hC3);
    @(negedge clk);
    chk("t2_second_busy", int'(bi0.busy), 1);
    chk("t2_valid_cleared", int'(bi0.data_valid), 0);
    chk("t2_data_retained", int'(bi0.data_out), 8'hC3);
    set_start(0, 1'b0);
    wait_done(0, -1, 8'h00, 8'h33, lat, wr, rd, oe);
    chk("t2_latency_b", lat, 111);
    @(negedge clk);

    // Capture edge: change on the last RD-low cycle vs after RD rise
    run_cycle(0, 8'h10, 8'h00, 39, 8'hFF, 0, lat, wr, rd, oe);
    @(negedge clk);
    chk("t3_late_in_rd", int'(bi0.data_out), 8'hFF);
    run_cycle(0, 8'h11, 8'h00, 40, 8'hFF, 0, lat, wr, rd, oe);
    @(negedge clk);
    chk("t3_after_rd", int'(bi0.data_out), 8'h00);

    // Reset in the middle of the data strobe
    set_start(0, 1'b1); set_addr(0, 8'h44); set_bus(0, 8'h77);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (35) @(negedge clk);
    chk("t4_in_rd", int'(bi0.RD), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_CS", int'(bi0.CS), 1);
    chk("t4_RD", int'(bi0.RD), 1);
    chk("t4_bus_oe", int'(bi0.bus_oe), 0);
    chk("t4_data_valid", int'(bi0.data_valid), 0);
    chk("t4_busy", int'(bi0.busy), 0);
    dn = 0;
    repeat (150) begin
      @(negedge clk);
      if (bi0.done) dn++;
    end
    chk("t4_no_done", dn, 0);

    // All phases one cycle long
    run_cycle(1, 8'hA5, 8'h3C, -1, 8'h00, 0, lat, wr, rd, oe);
    chk("t5_latency", lat, 7);
    chk("t5_wr_low", wr, 1);
    chk("t5_rd_low", rd, 1);
    chk("t5_addr_drive", oe, 3);
    @(negedge clk);
    chk("t5_data_out", int'(bi1.data_out), 8'h3C);
    chk("t5_data_valid", int'(bi1.data_valid), 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
